// File: rtl/chrono_pkg.sv
// Shared types and constants for the chrono_timer stopwatch/countdown block.
package chrono_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t min_tens;
      bcd_t min_units;
      bcd_t sec_tens;
      bcd_t sec_units;
   } time_t;

   // Active-low segments, bit 7 = dp (off), bits 6:0 = g..a
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Binary 0..99 to two BCD digits {tens, units}
   function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

endpackage

// File: rtl/chrono_timer_seg7_decoder.sv
// Single BCD digit to active-low seven-segment pattern; non-BCD codes blank.
module seg7_decoder
   import chrono_pkg::*;
(
   input  bcd_t       digit,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/chrono_timer.sv
// MM:SS stopwatch / countdown timer with lap freeze, preset load and
// four seven-segment digit outputs.
module chrono_timer
   import chrono_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100_000_000,
   parameter int unsigned MAX_MIN  = 59
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        pause,
   input  logic        lap,
   input  logic        clear,
   input  logic        load,
   input  logic        down,
   input  logic [6:0]  preset_min,
   input  logic [5:0]  preset_sec,
   output logic [15:0] bcd_disp,
   output logic [7:0]  seg_min_tens,
   output logic [7:0]  seg_min_units,
   output logic [7:0]  seg_sec_tens,
   output logic [7:0]  seg_sec_units,
   output logic        running,
   output logic        lap_active,
   output logic        done
);

   localparam int unsigned PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [6:0] MAX_MIN_BIN  = 7'(MAX_MIN);
   localparam logic [7:0] MAX_MIN_BCD  = bin_to_bcd(MAX_MIN_BIN);
   localparam time_t      TIME_ONE     = 16'h0001;

   state_t          state;
   logic [PW-1:0]   presc;
   time_t           cur;
   time_t           lap_time;
   time_t           up_next;
   time_t           dn_next;
   time_t           load_time;
   logic            down_mode;
   logic [5:0]      sec_clamp;
   logic [6:0]      min_clamp;

   // Preset clamping and binary-to-BCD conversion
   always_comb begin
      sec_clamp = (preset_sec > 6'd59) ? 6'd59 : preset_sec;
      min_clamp = (preset_min > MAX_MIN_BIN) ? MAX_MIN_BIN : preset_min;
      load_time = {bin_to_bcd(min_clamp), bin_to_bcd({1'b0, sec_clamp})};
   end

   // Next value on an up-count tick, wrapping MAX_MIN:59 to 00:00
   always_comb begin
      up_next = cur;
      if (cur.sec_units != 4'd9) begin
         up_next.sec_units = cur.sec_units + 4'd1;
      end else begin
         up_next.sec_units = 4'd0;
         if (cur.sec_tens != 4'd5) begin
            up_next.sec_tens = cur.sec_tens + 4'd1;
         end else begin
            up_next.sec_tens = 4'd0;
            if ({cur.min_tens, cur.min_units} == MAX_MIN_BCD) begin
               up_next.min_tens  = 4'd0;
               up_next.min_units = 4'd0;
            end else if (cur.min_units == 4'd9) begin
               up_next.min_units = 4'd0;
               up_next.min_tens  = cur.min_tens + 4'd1;
            end else begin
               up_next.min_units = cur.min_units + 4'd1;
            end
         end
      end
   end

   // Next value on a down-count tick; never evaluated at 00:00 while running
   always_comb begin
      dn_next = cur;
      if (cur.sec_units != 4'd0) begin
         dn_next.sec_units = cur.sec_units - 4'd1;
      end else begin
         dn_next.sec_units = 4'd9;
         if (cur.sec_tens != 4'd0) begin
            dn_next.sec_tens = cur.sec_tens - 4'd1;
         end else begin
            dn_next.sec_tens = 4'd5;
            if (cur.min_units != 4'd0) begin
               dn_next.min_units = cur.min_units - 4'd1;
            end else begin
               dn_next.min_units = 4'd9;
               dn_next.min_tens  = cur.min_tens - 4'd1;
            end
         end
      end
   end

   // Control FSM, prescaler, time and lap registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         presc      <= '0;
         cur        <= '0;
         lap_time   <= '0;
         lap_active <= 1'b0;
         running    <= 1'b0;
         done       <= 1'b0;
         down_mode  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (clear) begin
            state      <= IDLE;
            presc      <= '0;
            cur        <= '0;
            lap_time   <= '0;
            lap_active <= 1'b0;
            running    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (load) begin
                     cur <= load_time;
                  end else if (start && !(down && cur == time_t'(16'h0000))) begin
                     state     <= RUN;
                     running   <= 1'b1;
                     down_mode <= down;
                     presc     <= '0;
                  end
               end
               RUN: begin
                  if (!load && !start) begin
                     if (pause) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                     end else if (lap) begin
                        lap_active <= !lap_active;
                        lap_time   <= cur;
                     end
                  end
                  // Expiry is assigned last so it overrides a same-cycle pause
                  if (presc == PRESC_LAST) begin
                     presc <= '0;
                     cur   <= down_mode ? dn_next : up_next;
                     if (down_mode && cur == TIME_ONE) begin
                        state      <= DONE;
                        running    <= 1'b0;
                        done       <= 1'b1;
                        lap_active <= 1'b0;
                     end
                  end else begin
                     presc <= presc + PW'(1);
                  end
               end
               PAUSE: begin
                  if (!load) begin
                     if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                     end else if (!pause && lap) begin
                        lap_active <= 1'b0;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bcd_disp = lap_active ? lap_time : cur;

   seg7_decoder u_seg_min_tens  (.digit(bcd_disp[15:12]), .seg(seg_min_tens));
   seg7_decoder u_seg_min_units (.digit(bcd_disp[11:8]),  .seg(seg_min_units));
   seg7_decoder u_seg_sec_tens  (.digit(bcd_disp[7:4]),   .seg(seg_sec_tens));
   seg7_decoder u_seg_sec_units (.digit(bcd_disp[3:0]),   .seg(seg_sec_units));

endmodule

// File: tb/tb_chrono_timer.sv
// Directed self-checking bench for chrono_timer (TICK_DIV=4) and seg7_decoder.
module tb_chrono_timer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, pause = 1'b0, lap = 1'b0, clear = 1'b0, load = 1'b0;
   logic        down = 1'b0;
   logic [6:0]  preset_min = '0;
   logic [5:0]  preset_sec = '0;

   logic [15:0] bcd_disp, r_bcd_disp;
   logic [7:0]  seg_mt, seg_mu, seg_st, seg_su;
   logic [7:0]  r_seg_mt, r_seg_mu, r_seg_st, r_seg_su;
   logic        running, lap_active, done;
   logic        r_running, r_lap_active, r_done;

   logic [3:0]  dec_in = '0;
   logic [7:0]  dec_out;
   logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   chrono_timer #(.TICK_DIV(4), .MAX_MIN(59)) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .lap(lap), .clear(clear),
      .load(load), .down(down), .preset_min(preset_min), .preset_sec(preset_sec),
      .bcd_disp(bcd_disp), .seg_min_tens(seg_mt), .seg_min_units(seg_mu),
      .seg_sec_tens(seg_st), .seg_sec_units(seg_su),
      .running(running), .lap_active(lap_active), .done(done));

   chrono_timer #(.TICK_DIV(4), .MAX_MIN(1)) dut_r (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .lap(lap), .clear(clear),
      .load(load), .down(down), .preset_min(preset_min), .preset_sec(preset_sec),
      .bcd_disp(r_bcd_disp), .seg_min_tens(r_seg_mt), .seg_min_units(r_seg_mu),
      .seg_sec_tens(r_seg_st), .seg_sec_units(r_seg_su),
      .running(r_running), .lap_active(r_lap_active), .done(r_done));

   seg7_decoder u_dec (.digit(dec_in), .seg(dec_out));

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive {clear, load, start, pause, lap} for one cycle; called at a negedge
   task automatic pulse(input logic [4:0] c);
      {clear, load, start, pause, lap} = c;
      @(negedge clk);
      {clear, load, start, pause, lap} = 5'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      cyc(2);
      checks++; if (bcd_disp !== 16'h0000) begin failures++; $display("FAIL reset_bcd got=%h exp=0000", bcd_disp); end
      checks++; if ({seg_mt, seg_mu, seg_st, seg_su} !== 32'hC0C0C0C0) begin failures++; $display("FAIL reset_seg got=%h exp=c0c0c0c0", {seg_mt, seg_mu, seg_st, seg_su}); end
      checks++; if ({running, lap_active, done} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {running, lap_active, done}); end
      rst = 1'b0;
      cyc(1);
   endtask

   task automatic test_up_count;
      pulse(5'b10000);
      down = 1'b0;
      pulse(5'b00100);
      cyc(239);
      checks++; if (bcd_disp !== 16'h0059) begin failures++; $display("FAIL up_59 got=%h exp=0059", bcd_disp); end
      cyc(1);
      checks++; if (bcd_disp !== 16'h0100) begin failures++; $display("FAIL up_60 got=%h exp=0100", bcd_disp); end
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL up_running got=%b exp=1", running); end
      checks++; if ({seg_mt, seg_mu, seg_st, seg_su} !== 32'hC0F9C0C0) begin failures++; $display("FAIL up_seg got=%h exp=c0f9c0c0", {seg_mt, seg_mu, seg_st, seg_su}); end
   endtask

   task automatic test_rollover;
      pulse(5'b10000);
      down = 1'b0;
      pulse(5'b00100);
      cyc(240);
      checks++; if (r_bcd_disp !== 16'h0100) begin failures++; $display("FAIL roll_60 got=%h exp=0100", r_bcd_disp); end
      cyc(240);
      checks++; if (r_bcd_disp !== 16'h0000) begin failures++; $display("FAIL roll_120 got=%h exp=0000", r_bcd_disp); end
      checks++; if (r_running !== 1'b1) begin failures++; $display("FAIL roll_running got=%b exp=1", r_running); end
      checks++; if (bcd_disp !== 16'h0200) begin failures++; $display("FAIL roll_main got=%h exp=0200", bcd_disp); end
      cyc(4);
      checks++; if (r_bcd_disp !== 16'h0001) begin failures++; $display("FAIL roll_121 got=%h exp=0001", r_bcd_disp); end
   endtask

   task automatic test_count_down;
      pulse(5'b10000);
      preset_min = 7'd0; preset_sec = 6'd3;
      pulse(5'b01000);
      checks++; if (bcd_disp !== 16'h0003) begin failures++; $display("FAIL dn_load got=%h exp=0003", bcd_disp); end
      checks++; if (seg_su !== 8'hB0) begin failures++; $display("FAIL dn_seg3 got=%h exp=b0", seg_su); end
      down = 1'b1;
      pulse(5'b00100);
      down = 1'b0;
      cyc(11);
      checks++; if ({bcd_disp, done} !== {16'h0001, 1'b0}) begin failures++; $display("FAIL dn_pre got=%h/%b exp=0001/0", bcd_disp, done); end
      cyc(1);
      checks++; if ({bcd_disp, done, running} !== {16'h0000, 2'b10}) begin failures++; $display("FAIL dn_expire got=%h/%b%b exp=0000/10", bcd_disp, done, running); end
      cyc(1);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL dn_done_pulse got=%b exp=0", done); end
      cyc(40);
      pulse(5'b00101);
      cyc(4);
      checks++; if ({bcd_disp, running, lap_active} !== {16'h0000, 2'b00}) begin failures++; $display("FAIL dn_hold got=%h/%b%b exp=0000/00", bcd_disp, running, lap_active); end
   endtask

   task automatic test_down_zero;
      pulse(5'b10000);
      down = 1'b1;
      pulse(5'b00100);
      down = 1'b0;
      cyc(8);
      checks++; if ({bcd_disp, running} !== {16'h0000, 1'b0}) begin failures++; $display("FAIL dn_zero_ignore got=%h/%b exp=0000/0", bcd_disp, running); end
   endtask

   task automatic test_clamp_pause;
      pulse(5'b10000);
      preset_min = 7'd0; preset_sec = 6'd63;
      pulse(5'b01000);
      checks++; if (bcd_disp !== 16'h0059) begin failures++; $display("FAIL clamp_sec got=%h exp=0059", bcd_disp); end
      preset_min = 7'd120;
      pulse(5'b01000);
      checks++; if (bcd_disp !== 16'h5959) begin failures++; $display("FAIL clamp_min got=%h exp=5959", bcd_disp); end
      pulse(5'b10000);
      down = 1'b0;
      pulse(5'b00100);
      cyc(22);
      pulse(5'b00010);
      cyc(40);
      checks++; if ({bcd_disp, running} !== {16'h0005, 1'b0}) begin failures++; $display("FAIL pause_hold got=%h/%b exp=0005/0", bcd_disp, running); end
      pulse(5'b00100);
      checks++; if ({bcd_disp, running} !== {16'h0005, 1'b1}) begin failures++; $display("FAIL resume got=%h/%b exp=0005/1", bcd_disp, running); end
      cyc(1);
      checks++; if (bcd_disp !== 16'h0006) begin failures++; $display("FAIL resume_tick got=%h exp=0006", bcd_disp); end
      cyc(3);
      checks++; if (bcd_disp !== 16'h0006) begin failures++; $display("FAIL resume_gap got=%h exp=0006", bcd_disp); end
      cyc(1);
      checks++; if (bcd_disp !== 16'h0007) begin failures++; $display("FAIL resume_next got=%h exp=0007", bcd_disp); end
   endtask

   task automatic test_lap;
      pulse(5'b10000);
      down = 1'b0;
      pulse(5'b00100);
      cyc(28);
      pulse(5'b00001);
      checks++; if ({bcd_disp, lap_active} !== {16'h0007, 1'b1}) begin failures++; $display("FAIL lap_set got=%h/%b exp=0007/1", bcd_disp, lap_active); end
      cyc(12);
      checks++; if (bcd_disp !== 16'h0007) begin failures++; $display("FAIL lap_frozen got=%h exp=0007", bcd_disp); end
      pulse(5'b00001);
      checks++; if ({bcd_disp, lap_active} !== {16'h0010, 1'b0}) begin failures++; $display("FAIL lap_release got=%h/%b exp=0010/0", bcd_disp, lap_active); end
      pulse(5'b00001);
      pulse(5'b00010);
      checks++; if ({bcd_disp, lap_active} !== {16'h0010, 1'b1}) begin failures++; $display("FAIL lap_in_pause got=%h/%b exp=0010/1", bcd_disp, lap_active); end
      pulse(5'b00001);
      checks++; if ({bcd_disp, lap_active} !== {16'h0011, 1'b0}) begin failures++; $display("FAIL lap_pause_rel got=%h/%b exp=0011/0", bcd_disp, lap_active); end
      pulse(5'b00001);
      checks++; if (lap_active !== 1'b0) begin failures++; $display("FAIL lap_pause_noset got=%b exp=0", lap_active); end
   endtask

   task automatic test_async_reset;
      pulse(5'b10000);
      down = 1'b0;
      pulse(5'b00100);
      cyc(20);
      pulse(5'b00001);
      #2 rst = 1'b1;
      #1;
      checks++; if ({bcd_disp, running, lap_active, done} !== {16'h0000, 3'b000}) begin failures++; $display("FAIL async_rst got=%h/%b%b%b exp=0000/000", bcd_disp, running, lap_active, done); end
      checks++; if ({seg_mt, seg_mu, seg_st, seg_su} !== 32'hC0C0C0C0) begin failures++; $display("FAIL async_seg got=%h exp=c0c0c0c0", {seg_mt, seg_mu, seg_st, seg_su}); end
      @(negedge clk);
      rst = 1'b0;
      cyc(12);
      checks++; if ({bcd_disp, running} !== {16'h0000, 1'b0}) begin failures++; $display("FAIL post_rst got=%h/%b exp=0000/0", bcd_disp, running); end
   endtask

   task automatic test_priority;
      pulse(5'b10000);
      down = 1'b0;
      pulse(5'b00100);
      cyc(6);
      pulse(5'b00001);
      pulse(5'b10101);
      checks++; if ({bcd_disp, running, lap_active} !== {16'h0000, 2'b00}) begin failures++; $display("FAIL prio_clear got=%h/%b%b exp=0000/00", bcd_disp, running, lap_active); end
      preset_min = 7'd0; preset_sec = 6'd5;
      pulse(5'b01100);
      checks++; if ({bcd_disp, running} !== {16'h0005, 1'b0}) begin failures++; $display("FAIL prio_load got=%h/%b exp=0005/0", bcd_disp, running); end
   endtask

   task automatic test_decoder;
      for (int i = 0; i < 16; i++) begin
         dec_in = 4'(i);
         #1;
         checks++; if (dec_out !== seg_tab[i]) begin failures++; $display("FAIL seg_dec d=%0d got=%h exp=%h", i, dec_out, seg_tab[i]); end
      end
   endtask

   initial begin
      test_reset;
      test_up_count;
      test_rollover;
      test_count_down;
      test_down_zero;
      test_clamp_pause;
      test_lap;
      test_async_reset;
      test_priority;
      test_decoder;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
